bfs_level_sequencer: RTL and testbench

Phase controller for one `bfs_pipeline` lane.
- Each BFS iteration, it resets the lane, streams a vertex-level load into the lane's BRAM (`control=1`), then streams an edge list against it (`control=2`).
- It drains the 3-stage pipe and counts emitted frontier updates.
- It then decides whether to run the next level or finish.
- It sits between the AFU input stream and the pipeline, and reports per-level status to the host-side logic.

---
 rtl/bfs_level_sequencer_pkg.sv | 21 ++
 rtl/bfs_level_sequencer_if.sv | 27 ++
 rtl/bfs_level_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_bfs_level_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bfs_level_sequencer_pkg.sv
// Shared encodings for the BFS level sequencer: pipeline control codes, FSM states,
// and the default pipeline latency.
package bfs_level_sequencer_pkg;

  localparam logic [1:0] CTRL_IDLE    = 2'd0;
  localparam logic [1:0] CTRL_LOAD    = 2'd1;
  localparam logic [1:0] CTRL_SCATTER = 2'd2;

  localparam int PIPE_LAT_DEFAULT = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LD_INIT,
    ST_LOAD,
    ST_SCATTER,
    ST_DRAIN,
    ST_LEVEL_END,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/bfs_level_sequencer_if.sv
// Stream and pipeline-side signals of one BFS lane. The master modport is the
// sequencer; the slave modport is the AFU source plus the bfs_pipeline.
interface bfs_level_sequencer_if #(
  parameter int LEVEL_W = 8
);
  logic [511:0]       in_word;
  logic               in_valid;
  logic               in_ready;
  logic               pipe_rst;
  logic [511:0]       word_in;
  logic               word_in_valid;
  logic [1:0]         control;
  logic [LEVEL_W-1:0] current_level;
  logic               last_input_in;
  logic               valid_out;
  logic               last_input_out;

  modport master (
    input  in_word, in_valid, valid_out, last_input_out,
    output in_ready, pipe_rst, word_in, word_in_valid, control, current_level, last_input_in
  );

  modport slave (
    output in_word, in_valid, valid_out, last_input_out,
    input  in_ready, pipe_rst, word_in, word_in_valid, control, current_level, last_input_in
  );
endinterface

// File: rtl/bfs_level_sequencer.sv
// Per-level phase controller for a bfs_pipeline lane: reset, load, scatter, drain,
// then decide on the next level. All outputs are registered.
module bfs_level_sequencer
  import bfs_level_sequencer_pkg::*;
#(
  parameter int PIPE_LAT = PIPE_LAT_DEFAULT,
  parameter int LEVEL_W  = 8,
  parameter int CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_load_words,
  input  logic [CNT_W-1:0]   num_edge_words,
  input  logic [LEVEL_W-1:0] max_level,
  bfs_level_sequencer_if.master io,
  output logic               busy,
  output logic               level_done,
  output logic [CNT_W-1:0]   level_updates,
  output logic [CNT_W-1:0]   total_updates,
  output logic               done
);

  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
  localparam logic [LEVEL_W-1:0] LVL_ONE = LEVEL_W'(1);
  // Fallback exit so a lost last_input_out cannot hang the lane; normally unreached.
  localparam logic [CNT_W-1:0]   DRAIN_GUARD = CNT_W'(4 * (PIPE_LAT + 1));

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   n_load_q, n_load_d, n_edge_q, n_edge_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]   level_upd_q, level_upd_d, total_upd_q, total_upd_d;
  logic [LEVEL_W-1:0] max_lvl_q, max_lvl_d, level_q, level_d;
  logic [511:0]       word_q, word_d;
  logic [1:0]         ctrl_q, ctrl_d;
  logic               word_vld_q, word_vld_d, last_in_q, last_in_d;
  logic               in_rdy_q, in_rdy_d, pipe_rst_q, pipe_rst_d;
  logic               busy_q, busy_d, level_done_q, level_done_d, done_q, done_d;
  logic               xfer, count_en;

  assign xfer     = io.in_valid & in_rdy_q;
  assign count_en = io.valid_out & ((state_q == ST_SCATTER) | (state_q == ST_DRAIN));

  always_comb begin
    state_d     = state_q;
    n_load_d    = n_load_q;
    n_edge_d    = n_edge_q;
    max_lvl_d   = max_lvl_q;
    level_d     = level_q;
    word_cnt_d  = word_cnt_q;
    level_upd_d = level_upd_q;
    total_upd_d = total_upd_q;
    word_d      = word_q;
    ctrl_d      = ctrl_q;
    word_vld_d  = 1'b0;
    last_in_d   = 1'b0;

    if (count_en) begin
      if (level_upd_q != '1) level_upd_d = level_upd_q + CNT_ONE;
      if (total_upd_q != '1) total_upd_d = total_upd_q + CNT_ONE;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          n_load_d    = num_load_words;
          n_edge_d    = num_edge_words;
          max_lvl_d   = max_level;
          level_d     = '0;
          total_upd_d = '0;
          state_d     = ST_LD_INIT;
        end
      end
      ST_LD_INIT: begin
        word_cnt_d  = '0;
        level_upd_d = '0;
        state_d     = ST_LOAD;
      end
      ST_LOAD: begin
        if (n_load_q == '0) begin
          state_d = ST_SCATTER;
        end else if (xfer) begin
          word_d     = io.in_word;
          word_vld_d = 1'b1;
          ctrl_d     = CTRL_LOAD;
          word_cnt_d = word_cnt_q + CNT_ONE;
          if (word_cnt_q + CNT_ONE == n_load_q) begin
            last_in_d  = 1'b1;
            word_cnt_d = '0;
            state_d    = ST_SCATTER;
          end
        end
      end
      ST_SCATTER: begin
        if (n_edge_q == '0) begin
          state_d = ST_LEVEL_END;
        end else if (xfer) begin
          word_d     = io.in_word;
          word_vld_d = 1'b1;
          ctrl_d     = CTRL_SCATTER;
          word_cnt_d = word_cnt_q + CNT_ONE;
          if (word_cnt_q + CNT_ONE == n_edge_q) begin
            last_in_d  = 1'b1;
            word_cnt_d = '0;
            state_d    = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        word_cnt_d = word_cnt_q + CNT_ONE;
        if (io.last_input_out || (word_cnt_q == DRAIN_GUARD)) state_d = ST_LEVEL_END;
      end
      ST_LEVEL_END: begin
        if ((level_upd_q == '0) || (level_q == max_lvl_q)) begin
          state_d = ST_FINISH;
        end else begin
          level_d = level_q + LVL_ONE;
          state_d = ST_LD_INIT;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Registered outputs are decoded from the next state so they line up with it.
    in_rdy_d     = ((state_d == ST_LOAD) && (n_load_d != '0)) ||
                   ((state_d == ST_SCATTER) && (n_edge_d != '0));
    pipe_rst_d   = (state_d == ST_LD_INIT);
    busy_d       = (state_d != ST_IDLE);
    level_done_d = (state_d == ST_LEVEL_END);
    done_d       = (state_d == ST_FINISH);
    if ((state_d == ST_IDLE) || (state_d == ST_LD_INIT)) ctrl_d = CTRL_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      n_load_q     <= '0;
      n_edge_q     <= '0;
      max_lvl_q    <= '0;
      level_q      <= '0;
      word_cnt_q   <= '0;
      level_upd_q  <= '0;
      total_upd_q  <= '0;
      word_q       <= '0;
      ctrl_q       <= CTRL_IDLE;
      word_vld_q   <= 1'b0;
      last_in_q    <= 1'b0;
      in_rdy_q     <= 1'b0;
      pipe_rst_q   <= 1'b0;
      busy_q       <= 1'b0;
      level_done_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_load_q     <= n_load_d;
      n_edge_q     <= n_edge_d;
      max_lvl_q    <= max_lvl_d;
      level_q      <= level_d;
      word_cnt_q   <= word_cnt_d;
      level_upd_q  <= level_upd_d;
      total_upd_q  <= total_upd_d;
      word_q       <= word_d;
      ctrl_q       <= ctrl_d;
      word_vld_q   <= word_vld_d;
      last_in_q    <= last_in_d;
      in_rdy_q     <= in_rdy_d;
      pipe_rst_q   <= pipe_rst_d;
      busy_q       <= busy_d;
      level_done_q <= level_done_d;
      done_q       <= done_d;
    end
  end

  assign io.in_ready      = in_rdy_q;
  assign io.pipe_rst      = pipe_rst_q;
  assign io.word_in       = word_q;
  assign io.word_in_valid = word_vld_q;
  assign io.control       = ctrl_q;
  assign io.current_level = level_q;
  assign io.last_input_in = last_in_q;
  assign busy             = busy_q;
  assign level_done       = level_done_q;
  assign level_updates    = level_upd_q;
  assign total_updates    = total_upd_q;
  assign done             = done_q;

endmodule

// File: tb/tb_bfs_level_sequencer.sv
// Directed bench for bfs_level_sequencer with a 3-cycle pipeline model and an AFU source.
module tb_bfs_level_sequencer;
  import bfs_level_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] num_load_words = '0;
  logic [31:0] num_edge_words = '0;
  logic [7:0]  max_level = '0;
  logic        busy, level_done, done;
  logic [31:0] level_updates, total_updates;

  bfs_level_sequencer_if #(.LEVEL_W(8)) io();

  bfs_level_sequencer #(.PIPE_LAT(3), .LEVEL_W(8), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .start(start),
    .num_load_words(num_load_words), .num_edge_words(num_edge_words), .max_level(max_level),
    .io(io), .busy(busy), .level_done(level_done), .level_updates(level_updates),
    .total_updates(total_updates), .done(done)
  );

  always #5 clk = ~clk;

  // Pipeline model: scatter words with bit0 set emit an update 3 cycles later.
  logic [2:0] pv = '0, pl = '0;
  always @(posedge clk) begin
    if (rst || io.pipe_rst) begin
      pv <= '0;
      pl <= '0;
    end else begin
      pv <= {pv[1:0], io.word_in_valid && (io.control == 2'd2) && io.word_in[0]};
      pl <= {pl[1:0], io.word_in_valid && (io.control == 2'd2) && io.last_input_in};
    end
  end
  assign io.valid_out      = pv[2];
  assign io.last_input_out = pl[2];

  // AFU source
  logic [511:0] words [0:31];
  int src_n = 0, src_epoch = 0, src_idx = 0;
  bit src_en = 1'b0, src_stall = 1'b0;
  initial begin
    int idx, ep;
    bit acc, ph;
    idx = 0; ep = 0; ph = 1'b0;
    io.in_valid = 1'b0;
    io.in_word  = '0;
    forever begin
      @(negedge clk);
      acc = io.in_valid && io.in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      if (ep != src_epoch) begin ep = src_epoch; idx = 0; end
      ph = ~ph;
      src_idx = idx;
      if (src_en && idx < src_n && (!src_stall || ph)) begin
        io.in_valid = 1'b1;
        io.in_word  = words[idx];
      end else begin
        io.in_valid = 1'b0;
      end
    end
  end

  // Event monitor
  int n_ld = 0, n_prst = 0, n_wv = 0, n_last = 0, n_last_sc = 0, n_done = 0;
  int last_lu = 0, tot_at_done = 0, lvl_at_done = 0;
  always @(negedge clk) begin
    if (level_done) begin n_ld++; last_lu = int'(level_updates); end
    if (io.pipe_rst) n_prst++;
    if (io.word_in_valid) n_wv++;
    if (io.last_input_in) n_last++;
    if (io.last_input_in && io.control == CTRL_SCATTER) n_last_sc++;
    if (done) begin n_done++; tot_at_done = int'(total_updates); lvl_at_done = int'(io.current_level); end
  end

  int checks = 0, failures = 0;
  int b_ld, b_prst, b_wv, b_last, b_last_sc, b_done;
  logic [511:0] exp_w;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic snap();
    b_ld = n_ld; b_prst = n_prst; b_wv = n_wv; b_last = n_last; b_last_sc = n_last_sc; b_done = n_done;
  endtask

  function automatic logic [511:0] mk(input int k, input bit m);
    mk = '0;
    mk[31:16] = 16'hA500 + k[15:0];
    mk[0] = m;
  endfunction

  // Stream layout per level: nl load words, then ne edge words; the first
  // upd0 (level 0) or updn (later levels) edge words produce an update.
  task automatic setup(input int nl, input int ne, input int nlev, input int upd0, input int updn);
    int k;
    k = 0;
    for (int l = 0; l < nlev; l++) begin
      for (int i = 0; i < nl; i++) begin words[k] = mk(k, 1'b0); k++; end
      for (int i = 0; i < ne; i++) begin
        words[k] = mk(k, (i < ((l == 0) ? upd0 : updn)));
        k++;
      end
    end
    src_n = k;
    src_epoch++;
    src_en = 1'b1;
    num_load_words = 32'(nl);
    num_edge_words = 32'(ne);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (done !== 1'b1 && k < 300) begin cyc(); k++; end
    chk(tag, 64'(k < 300), 64'd1);
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    chk("rst_busy", busy, 1'b0);
    chk("rst_ctrl", io.control, CTRL_IDLE);
    chk("rst_ready", io.in_ready, 1'b0);
    chk("rst_pipe_rst", io.pipe_rst, 1'b0);
    chk("rst_wvld", io.word_in_valid, 1'b0);
    chk("rst_counts", {level_updates, total_updates}, 64'd0);
    chk("rst_pulses", {done, level_done, io.last_input_in}, 3'b000);

    // Single level, cycle by cycle: load=2, edges=4, max_level=0, one matching edge
    setup(2, 4, 1, 1, 0);
    max_level = 8'd0;
    cyc();
    snap();
    pulse_start();                                      // c1: LD_INIT
    chk("s1_c1_pipe_rst", {io.pipe_rst, busy, io.in_ready}, 3'b110);
    chk("s1_c1_ctrl", io.control, CTRL_IDLE);
    cyc();                                              // c2: LOAD, no word yet
    chk("s1_c2_ready", {io.in_ready, io.pipe_rst, io.word_in_valid}, 3'b100);
    chk("s1_c2_ctrl", io.control, CTRL_IDLE);
    cyc();                                              // c3: first load word
    exp_w = words[0];
    chk("s1_c3_vld_ctrl", {io.word_in_valid, io.control, io.last_input_in}, 4'b1010);
    chk("s1_c3_word", io.word_in[63:0], exp_w[63:0]);
    cyc();                                              // c4: last load word
    chk("s1_c4_last", {io.word_in_valid, io.control, io.last_input_in}, 4'b1011);
    cyc();                                              // c5: first scatter word
    exp_w = words[2];
    chk("s1_c5_scatter", {io.word_in_valid, io.control, io.last_input_in}, 4'b1100);
    chk("s1_c5_word", io.word_in[63:0], exp_w[63:0]);
    repeat (3) cyc();                                   // c8: last scatter word
    chk("s1_c8_last", {io.word_in_valid, io.control, io.last_input_in, io.in_ready}, 5'b11010);
    repeat (3) cyc();                                   // c11: still draining
    chk("s1_c11_drain", {io.word_in_valid, io.control, level_done}, 4'b0100);
    cyc();                                              // c12: level end
    chk("s1_c12_level_done", {level_done, done}, 2'b10);
    chk("s1_c12_level_updates", level_updates, 32'd1);
    cyc();                                              // c13: finish
    chk("s1_c13_done", {done, level_done}, 2'b10);
    chk("s1_c13_total", total_updates, 32'd1);
    chk("s1_c13_level", io.current_level, 8'd0);
    cyc();                                              // c14: idle
    chk("s1_c14_idle", {busy, io.control}, 3'b000);
    chk("s1_level_done_count", 64'(n_ld - b_ld), 64'd1);
    src_en = 1'b0;

    // Early stop: level 1 produces no updates, max_level=5
    setup(1, 2, 2, 1, 0);
    max_level = 8'd5;
    cyc();
    snap();
    pulse_start();
    wait_done("s2_done_seen");
    chk("s2_level_done_count", 64'(n_ld - b_ld), 64'd2);
    chk("s2_level", 64'(lvl_at_done), 64'd1);
    chk("s2_total", 64'(tot_at_done), 64'd1);
    chk("s2_last_level_updates", 64'(last_lu), 64'd0);
    chk("s2_pipe_rst_count", 64'(n_prst - b_prst), 64'd2);
    src_en = 1'b0;

    // Max-level stop: 3 updates per level, max_level=2; a stray start mid-run is ignored
    setup(1, 3, 3, 3, 3);
    max_level = 8'd2;
    cyc();
    snap();
    pulse_start();
    repeat (6) cyc();
    pulse_start();
    wait_done("s3_done_seen");
    chk("s3_level_done_count", 64'(n_ld - b_ld), 64'd3);
    chk("s3_total", 64'(tot_at_done), 64'd9);
    chk("s3_level", 64'(lvl_at_done), 64'd2);
    chk("s3_last_level_updates", 64'(last_lu), 64'd3);
    chk("s3_done_count", 64'(n_done - b_done), 64'd1);
    src_en = 1'b0;

    // Stalls: in_valid toggles 1,0,1,0 over two levels
    src_stall = 1'b1;
    setup(2, 2, 2, 1, 1);
    max_level = 8'd1;
    cyc();
    snap();
    pulse_start();
    wait_done("s4_done_seen");
    chk("s4_words_issued", 64'(n_wv - b_wv), 64'd8);
    chk("s4_last_in_count", 64'(n_last - b_last), 64'd4);
    chk("s4_last_in_scatter", 64'(n_last_sc - b_last_sc), 64'd2);
    chk("s4_pipe_rst_count", 64'(n_prst - b_prst), 64'd2);
    chk("s4_total", 64'(tot_at_done), 64'd2);
    exp_w = words[7];
    chk("s4_final_word", io.word_in[63:0], exp_w[63:0]);
    src_en = 1'b0;
    src_stall = 1'b0;

    // Zero edges: SCATTER goes straight to LEVEL_END, spare AFU word must not be taken
    setup(1, 0, 1, 0, 0);
    words[1] = mk(1, 1'b1);
    src_n = 2;
    max_level = 8'd3;
    cyc();
    snap();
    pulse_start();
    wait_done("s5_done_seen");
    chk("s5_level_done_count", 64'(n_ld - b_ld), 64'd1);
    chk("s5_level_updates", 64'(last_lu), 64'd0);
    chk("s5_no_scatter_last", 64'(n_last_sc - b_last_sc), 64'd0);
    chk("s5_words_issued", 64'(n_wv - b_wv), 64'd1);
    chk("s5_words_taken", 64'(src_idx), 64'd1);
    chk("s5_level", 64'(lvl_at_done), 64'd0);
    src_en = 1'b0;

    // Reset mid-DRAIN, then a fresh single-level run
    setup(2, 4, 1, 1, 0);
    max_level = 8'd0;
    cyc();
    snap();
    pulse_start();
    repeat (8) cyc();                                   // c9: draining
    chk("s6_in_drain", {busy, io.control, io.word_in_valid, io.in_ready}, 5'b11000);
    rst = 1'b1;
    start = 1'b1;
    src_en = 1'b0;
    cyc();
    chk("s6_rst_outputs", {busy, io.control, io.word_in_valid, io.in_ready, io.pipe_rst,
                           io.last_input_in, level_done, done}, 9'd0);
    chk("s6_rst_counts", {level_updates, total_updates}, 64'd0);
    chk("s6_rst_level", io.current_level, 8'd0);
    cyc();
    rst = 1'b0;
    start = 1'b0;
    cyc();
    chk("s6_start_ignored", {busy, io.pipe_rst}, 2'b00);
    chk("s6_no_pulses", 64'((n_ld - b_ld) + (n_done - b_done)), 64'd0);
    chk("s6_pipe_rst_once", 64'(n_prst - b_prst), 64'd1);
    setup(2, 4, 1, 1, 0);
    cyc();
    snap();
    pulse_start();
    wait_done("s6_done_seen");
    chk("s6_level_done_count", 64'(n_ld - b_ld), 64'd1);
    chk("s6_level_updates", 64'(last_lu), 64'd1);
    chk("s6_total", 64'(tot_at_done), 64'd1);
    chk("s6_words_issued", 64'(n_wv - b_wv), 64'd6);
    src_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
